serial_adder: RTL and testbench

//   Parametrised multi-cycle full adder: adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock.

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder: {cout,sum} = a + b + cin, DIGIT bits per clock over WIDTH/DIGIT RUN cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_width_check
            $error("serial_adder: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic             carry;
    logic [CW-1:0]    count;
    logic [DIGIT:0]   dsum;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    assign dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // New digit enters at the MSB end; the concat avoids a zero-width slice when DIGIT==WIDTH.
    assign cat      = {dsum[DIGIT-1:0], acc};
    assign acc_next = cat[WIDTH+DIGIT-1:DIGIT];
    assign last     = (count == CW'(N - 1));

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    logic c_msb;
    assign c_msb = dsum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        acc   <= '0;
                        count <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    acc   <= acc_next;
                    carry <= dsum[DIGIT];
                    count <= count + CW'(1);
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= acc_next;
                        cout  <= dsum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= c_msb ^ dsum[DIGIT];
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8/1 bit-serial, 4/2 exhaustive and 4/4 single-cycle instances.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=8, DIGIT=1
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, cout8;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
`endif

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    // WIDTH=4, DIGIT=2
    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       busy4, done4, cout4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf4;
`endif

    serial_adder #(.WIDTH(4), .DIGIT(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    // WIDTH=4, DIGIT=4 (single RUN cycle)
    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [3:0] a1 = '0, b1 = '0, sum1;
    logic       busy1, done1, cout1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf1;
`endif

    serial_adder #(.WIDTH(4), .DIGIT(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts an add on dut8 and returns cycles from the accepting edge to done (capped at 20).
    task automatic add8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, output int lat);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, pulses, last_pulse, done_seen;
        logic [4:0] exp5;

        // Reset state
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf8, 0);
`endif
        step();
        step();
        rst = 1'b0;
        step();

        // Test 1: FF + 01, busy for 8 cycles, done after
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_busy_%0d", i), {busy8, done8}, 2'b10);
            step();
        end
        check("t1_done", {busy8, done8}, 2'b01);
        check("t1_result", {cout8, sum8}, 9'h100);
        step();
        check("t1_done_pulse", done8, 0);
        check("t1_sum_held", {cout8, sum8}, 9'h100);

        // All-ones + 0 + cin=1
        add8(8'hFF, 8'h00, 1'b1, lat);
        check("ones_cin_lat", lat, 8);
        check("ones_cin_res", {cout8, sum8}, 9'h100);

        add8(8'hA5, 8'h3C, 1'b1, lat);
        check("a5_3c_res", {cout8, sum8}, 9'h0E2);

        // Test 3: start mid-RUN is ignored
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        a8 = 8'hFF; start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            step();
            lat++;
        end
        check("t3_done_lat", lat, 4);
        check("t3_res", {cout8, sum8}, 9'h046);

        // Test 4: reset mid-add aborts
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        check("t4_busy", busy8, 0);
        check("t4_sum", sum8, 0);
        check("t4_cout", cout8, 0);
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8) done_seen++;
        end
        check("t4_no_done", done_seen, 0);
        add8(8'h01, 8'h01, 1'b0, lat);
        check("t4_next_res", {cout8, sum8}, 9'h002);
        step();

        // Test 5: start held high -> done every 9 cycles
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        step();
        pulses = 0; last_pulse = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            check($sformatf("t5_excl_%0d", cyc), busy8 ^ done8, 1);
            if (done8) begin
                if (last_pulse >= 0) check($sformatf("t5_period_%0d", cyc), cyc - last_pulse, 9);
                last_pulse = cyc;
                pulses++;
            end
            if (pulses > 0) check($sformatf("t5_sum_%0d", cyc), {cout8, sum8}, 9'h030);
            step();
        end
        check("t5_pulses", pulses, 4);
        start8 = 1'b0;
        step(); step(); step(); step(); step(); step(); step(); step(); step(); step();

`ifdef SERIAL_ADDER_OVF_EN
        // Test 6: signed overflow
        add8(8'h7F, 8'h01, 1'b0, lat);
        check("ovf_7f_res", {ovf8, cout8, sum8}, 10'h280);
        add8(8'hFF, 8'h01, 1'b0, lat);
        check("ovf_ff_res", {ovf8, cout8, sum8}, 10'h100);
        add8(8'h80, 8'h80, 1'b0, lat);
        check("ovf_80_res", {ovf8, cout8, sum8}, 10'h300);
`endif

        // Test 2: WIDTH=4 DIGIT=2 exhaustive; done exactly 2 cycles after accept
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    step();
                    start4 = 1'b0;
                    step();
                    check("w4_early", done4, 0);
                    step();
                    exp5 = 5'(ia + ib + ic);
                    check($sformatf("w4_%0h_%0h_%0d", ia, ib, ic), {done4, cout4, sum4}, {1'b1, exp5});
                end
            end
        end

        // DIGIT==WIDTH: single RUN cycle
        a1 = 4'hF; b1 = 4'h0; cin1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("n1_busy", {busy1, done1}, 2'b10);
        step();
        check("n1_ones", {done1, cout1, sum1}, 6'b1_1_0000);
        a1 = 4'h7; b1 = 4'h8; cin1 = 1'b0; start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        check("n1_7_8", {done1, cout1, sum1}, 6'b1_0_1111);
        a1 = 4'h9; b1 = 4'h9; cin1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        check("n1_9_9", {done1, cout1, sum1}, 6'b1_1_0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
